// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over imem req/ack, forms the next PC from the ImmOp/ALU targets.
// Latency: req in cycle N, instr_valid_o in N+1 after the ack edge. stall_i holds VALID; TRAP on a misaligned target.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [1:0]            PCSrc_i,
   input  logic [DATA_WIDTH-1:0] ImmOp_i,
   input  logic [DATA_WIDTH-1:0] ALUResult_i,
   input  logic                  stall_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic                  imem_ack_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] PC_o,
   output logic [DATA_WIDTH-1:0] PCPlus4_o,
   output logic                  misalign_o
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID, TRAP} state_t;

   localparam logic [DATA_WIDTH-1:0] FOUR     = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] LSB_MASK = ~DATA_WIDTH'(1);

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] pc, pc_nxt;
   logic [DATA_WIDTH-1:0] instr, instr_nxt;
   logic [DATA_WIDTH-1:0] target;
   logic                  misalign, misalign_nxt;

   // Candidate next PC; PCSrc 11 falls back to sequential.
   always_comb begin
      target = pc + FOUR;
      case (PCSrc_i)
         2'b01:   target = pc + ImmOp_i;
         2'b10:   target = ALUResult_i & LSB_MASK;
         default: target = pc + FOUR;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         instr    <= '0;
         misalign <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         instr    <= instr_nxt;
         misalign <= misalign_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr;
      misalign_nxt = misalign;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            if (imem_ack_i) begin
               instr_nxt = imem_rdata_i;
               state_nxt = VALID;
            end
         end
         VALID: begin
            if (!stall_i) begin
               // A misaligned target freezes the PC at the faulting instruction.
               if (target[1:0] != 2'b00) begin
                  misalign_nxt = 1'b1;
                  state_nxt    = TRAP;
               end else begin
                  pc_nxt    = target;
                  state_nxt = FETCH;
               end
            end
         end
         TRAP:    state_nxt = TRAP;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode straight from state so an async reset drops req at once.
   assign imem_req_o    = (state == FETCH);
   assign imem_addr_o   = pc;
   assign instr_o       = instr;
   assign instr_valid_o = (state == VALID);
   assign PC_o          = pc;
   assign PCPlus4_o     = pc + FOUR;
   assign misalign_o    = misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side memory, scoreboard of expected {pc, instr} per fetch.
module tb_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [1:0]  PCSrc_i;
   logic [31:0] ImmOp_i, ALUResult_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_ack_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic [31:0] PC_o, PCPlus4_o;
   logic        misalign_o;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [63:0] sb_q[$];

   fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .PCSrc_i(PCSrc_i), .ImmOp_i(ImmOp_i),
      .ALUResult_i(ALUResult_i), .stall_i(stall_i), .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
      .instr_o(instr_o), .instr_valid_o(instr_valid_o), .PC_o(PC_o),
      .PCPlus4_o(PCPlus4_o), .misalign_o(misalign_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] addr);
      return (addr == 32'h0) ? 32'h0050_0093 : (addr ^ 32'h1234_0013);
   endfunction

   // Wait for a request, hold the ack off for 'waits' cycles, then answer and score.
   task automatic do_fetch(input int waits, input logic [31:0] exp_addr);
      int n = 0;
      logic [63:0] e;
      imem_ack_i = 1'b0;
      while (!imem_req_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("req_seen", {31'b0, imem_req_o}, 32'd1);
      chk("req_addr", imem_addr_o, exp_addr);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk_i);
         chk("wait_req", {31'b0, imem_req_o}, 32'd1);
         chk("wait_addr", imem_addr_o, exp_addr);
      end
      imem_ack_i   = 1'b1;
      imem_rdata_i = memf(exp_addr);
      sb_q.push_back({exp_addr, memf(exp_addr)});
      @(negedge clk_i);
      imem_ack_i = 1'b0;
      chk("valid", {31'b0, instr_valid_o}, 32'd1);
      chk("req_off", {31'b0, imem_req_o}, 32'd0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("instr", instr_o, e[31:0]);
         chk("pc", PC_o, e[63:32]);
         chk("pc_plus4", PCPlus4_o, e[63:32] + 32'd4);
      end
   endtask

   // One consume cycle from VALID with the given next-PC inputs.
   task automatic consume(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
      PCSrc_i     = src;
      ImmOp_i     = imm;
      ALUResult_i = alu;
      stall_i     = 1'b0;
      @(negedge clk_i);
      stall_i     = 1'b1;
      PCSrc_i     = 2'bxx;
      ImmOp_i     = 'x;
      ALUResult_i = 'x;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
      chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
      chk({tag, "_pc"}, PC_o, 32'h0);
      chk({tag, "_pc4"}, PCPlus4_o, 32'h4);
      chk({tag, "_mis"}, {31'b0, misalign_o}, 32'd0);
   endtask

   initial begin
      rst_n_i = 1'b0;
      PCSrc_i = 2'b00; ImmOp_i = '0; ALUResult_i = '0;
      stall_i = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = '0;
      repeat (2) @(negedge clk_i);
      check_reset_state("rst");
      chk("rst_instr", instr_o, 32'h0);
      rst_n_i = 1'b1;

      // T1: zero-wait fetch at RESET_PC
      @(negedge clk_i);
      do_fetch(0, 32'h0);
      chk("t1_instr", instr_o, 32'h0050_0093);

      consume(2'b00, '0, '0);
      do_fetch(0, 32'h4);
      consume(2'b01, 32'h0000_000C, '0);
      do_fetch(1, 32'h10);

      // T2: negative branch offset
      consume(2'b01, 32'hFFFF_FFF8, '0);
      do_fetch(0, 32'h08);
      consume(2'b11, '0, '0);
      do_fetch(0, 32'h0C);

      // T4: stall with a spurious ack
      for (int i = 0; i < 3; i++) begin
         imem_ack_i   = (i == 1);
         imem_rdata_i = 32'hDEAD_BEEF;
         @(negedge clk_i);
         chk("stall_instr", instr_o, memf(32'h0C));
         chk("stall_pc", PC_o, 32'h0C);
         chk("stall_req", {31'b0, imem_req_o}, 32'd0);
         chk("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      end
      imem_ack_i = 1'b0;
      consume(2'b00, '0, '0);
      do_fetch(0, 32'h10);

      // T3: JALR clears bit 0
      consume(2'b10, '0, 32'h0000_0101);
      do_fetch(0, 32'h100);

      // T5: wrap-around with a slow memory
      consume(2'b10, '0, 32'hFFFF_FFFC);
      do_fetch(3, 32'hFFFF_FFFC);
      chk("wrap_pc4", PCPlus4_o, 32'h0);
      consume(2'b00, '0, '0);
      do_fetch(0, 32'h0);

      // T3: misaligned JALR target traps
      consume(2'b10, '0, 32'h0000_0102);
      chk("trap_mis", {31'b0, misalign_o}, 32'd1);
      chk("trap_valid", {31'b0, instr_valid_o}, 32'd0);
      chk("trap_pc", PC_o, 32'h0);
      for (int i = 0; i < 4; i++) begin
         imem_ack_i   = 1'b1;
         imem_rdata_i = 32'hCAFE_F00D;
         @(negedge clk_i);
         chk("trap_req", {31'b0, imem_req_o}, 32'd0);
         chk("trap_hold_mis", {31'b0, misalign_o}, 32'd1);
         chk("trap_hold_instr", instr_o, 32'h0050_0093);
      end
      imem_ack_i = 1'b0;

      // Reset leaves TRAP and clears the sticky flag
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check_reset_state("trap_rst");
      rst_n_i = 1'b1;
      @(negedge clk_i);
      do_fetch(0, 32'h0);
      consume(2'b00, '0, '0);

      // T6: async reset mid-FETCH, then a late ack while in IDLE
      chk("t6_req_pre", {31'b0, imem_req_o}, 32'd1);
      chk("t6_addr_pre", imem_addr_o, 32'h4);
      #2 rst_n_i = 1'b0;
      #1 check_reset_state("t6");
      @(negedge clk_i);
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'h7777_7777;
      rst_n_i      = 1'b1;
      @(negedge clk_i);
      chk("t6_late_valid", {31'b0, instr_valid_o}, 32'd0);
      chk("t6_late_instr", instr_o, 32'h0);
      chk("t6_refetch_req", {31'b0, imem_req_o}, 32'd1);
      imem_ack_i = 1'b0;
      do_fetch(0, 32'h0);

      // Misaligned branch target also traps
      consume(2'b01, 32'h0000_0002, '0);
      chk("br_mis", {31'b0, misalign_o}, 32'd1);
      chk("br_req", {31'b0, imem_req_o}, 32'd0);
      chk("br_pc", PC_o, 32'h0);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
